// File: rtl/gray_pkg.sv
// Shared types and helpers for the binary-to-Gray transmit path.
//   enc_state_t : encoder FSM states
//   MODE_*      : encoding of mode_i sampled with start_i
//   bin2gray()  : width-agnostic binary to Gray conversion (zero-extend in, truncate out)
package gray_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    COUNT  = 2'd2,
    DRAIN  = 2'd3
  } enc_state_t;

  localparam logic MODE_STREAM = 1'b0;
  localparam logic MODE_COUNT  = 1'b1;

  localparam int unsigned GRAY_MAX_W = 64;

  // Callers zero-extend to GRAY_MAX_W and truncate the result back to their width;
  // the zero MSB makes the top Gray bit equal the top binary bit as required.
  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_fifo.sv
// Synchronous FIFO with MSB-compare full/empty detection.
//   clk, rst_n : clock, async active-low reset (pointers only; storage is not reset)
//   push_i     : write data_i (ignored while full)
//   pop_i      : advance head (ignored while empty)
//   data_o     : word at the head
//   full_o     : DEPTH entries stored
//   empty_o    : no entries stored
//   level_o    : current occupancy
module gray_fifo #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, rptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  // Same index with differing wrap bit means the write pointer lapped the read pointer.
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign level_o = wptr_q - rptr_q;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rptr_q[AW-1:0]];

  // Pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
      if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

  // Storage array
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/binary_to_gray_encoder.sv
// Binary-to-Gray transmit block: encodes upstream words (STREAM) or a free-running
// counter (COUNT) to Gray code and queues them for a valid/ready consumer.
//   clk, rst_n   : clock, async active-low reset
//   start_i      : start pulse, sampled in IDLE together with mode_i
//   mode_i       : 0 = STREAM, 1 = COUNT
//   stop_i       : stop pulse, moves STREAM/COUNT to DRAIN
//   bin_valid_i / bin_ready_o / bin_data_i    : upstream binary stream
//   gray_valid_o / gray_ready_i / gray_data_o : downstream Gray stream
//   busy_o       : FSM not in IDLE
module binary_to_gray_encoder
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             mode_i,
  input  logic             stop_i,
  input  logic             bin_valid_i,
  output logic             bin_ready_o,
  input  logic [WIDTH-1:0] bin_data_i,
  output logic             gray_valid_o,
  input  logic             gray_ready_i,
  output logic [WIDTH-1:0] gray_data_o,
  output logic             busy_o
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;

  enc_state_t       state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             fifo_full, fifo_empty;
  logic [LW-1:0]    fifo_level;
  logic             push, pop;
  logic [WIDTH-1:0] push_bin, push_gray;

  // Handshake flags depend only on flops, so there is no input-to-output path.
  assign bin_ready_o  = (state_q == STREAM) && !fifo_full;
  assign gray_valid_o = !fifo_empty;
  assign busy_o       = (state_q != IDLE);
  assign pop          = gray_valid_o && gray_ready_i;
  assign push_gray    = WIDTH'(bin2gray(GRAY_MAX_W'(push_bin)));

  // Push source selection
  always_comb begin
    push     = 1'b0;
    push_bin = bin_data_i;
    case (state_q)
      STREAM: push = bin_valid_i && bin_ready_o;
      COUNT: begin
        push     = !fifo_full;
        push_bin = cnt_q;
      end
      default: push = 1'b0;
    endcase
  end

  // Next-state and counter logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = (mode_i == MODE_STREAM) ? STREAM : COUNT;
          cnt_d   = '0;
        end
      end
      STREAM: begin
        if (stop_i) state_d = DRAIN;
      end
      COUNT: begin
        if (push)   cnt_d   = cnt_q + WIDTH'(1);
        if (stop_i) state_d = DRAIN;
      end
      DRAIN: begin
        // Leave once the FIFO is empty after this cycle's pop.
        if (fifo_empty || (pop && (fifo_level == LW'(1)))) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  gray_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  (push_gray),
    .pop_i   (pop),
    .data_o  (gray_data_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

endmodule

// File: tb/tb_binary_to_gray_encoder.sv
// Scoreboard bench for binary_to_gray_encoder: stimulus pushes expected Gray words,
// a negedge monitor pops and compares every word the DUT hands downstream.
module tb_binary_to_gray_encoder;

  localparam int unsigned W = 4;
  localparam int unsigned D = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_i, mode_i, stop_i;
  logic         bin_valid_i, bin_ready_o;
  logic [W-1:0] bin_data_i;
  logic         gray_valid_o, gray_ready_i;
  logic [W-1:0] gray_data_o;
  logic         busy_o;

  logic ready_fix, ready_rand, rnd_bit;

  int           n_tests = 0;
  int           n_fail  = 0;
  int           n_pops  = 0;
  int           gray_tbl [16];
  logic [W-1:0] exp_q [$];

  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_data  = '0;

  always #5 clk = ~clk;

  assign gray_ready_i = ready_rand ? rnd_bit : ready_fix;
  always @(posedge clk) begin
    #1;
    rnd_bit = 1'($urandom_range(0, 1));
  end

  binary_to_gray_encoder #(.WIDTH(W), .DEPTH(D)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .mode_i       (mode_i),
    .stop_i       (stop_i),
    .bin_valid_i  (bin_valid_i),
    .bin_ready_o  (bin_ready_o),
    .bin_data_i   (bin_data_i),
    .gray_valid_o (gray_valid_o),
    .gray_ready_i (gray_ready_i),
    .gray_data_o  (gray_data_o),
    .busy_o       (busy_o)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: a handshake seen at the negedge completes at the following posedge.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", int'(gray_valid_o), 1);
        chk("hold_data", int'(gray_data_o), int'(prev_data));
      end
      if (gray_valid_o && gray_ready_i) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_word: got %0d with no expected word (t=%0t)", gray_data_o, $time);
        end else begin
          chk("gray_data", int'(gray_data_o), int'(exp_q.pop_front()));
        end
        n_pops++;
      end
      prev_stall = gray_valid_o && !gray_ready_i;
      prev_data  = gray_data_o;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic m);
    mode_i  = m;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic stop_pulse();
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
  endtask

  // Present one word; stop_i optionally rides on the accepting edge.
  task automatic send(input logic [W-1:0] d, input bit with_stop);
    int k = 0;
    bin_valid_i = 1'b1;
    bin_data_i  = d;
    @(negedge clk);
    while (!bin_ready_o && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (!bin_ready_o) begin
      chk("send_timeout", int'(bin_ready_o), 1);
      bin_valid_i = 1'b0;
      tick();
      return;
    end
    stop_i = with_stop;
    exp_q.push_back(W'(gray_tbl[d]));
    tick();
    bin_valid_i = 1'b0;
    stop_i      = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    while (busy_o && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_idle"}, int'(busy_o), 0);
    tick();
  endtask

  initial begin
    int tbl [$];
    int n, k, base;

    // Reflected-binary construction of the 4-bit Gray sequence.
    tbl.push_back(0);
    for (int b = 0; b < 4; b++) begin
      n = tbl.size();
      for (int i = n - 1; i >= 0; i--) tbl.push_back(tbl[i] | (1 << b));
    end
    for (int i = 0; i < 16; i++) gray_tbl[i] = tbl[i];

    rst_n = 1'b0; start_i = 1'b0; mode_i = 1'b0; stop_i = 1'b0;
    bin_valid_i = 1'b0; bin_data_i = '0; ready_fix = 1'b0; ready_rand = 1'b0;
    repeat (3) tick();
    chk("rst_valid", int'(gray_valid_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_ready", int'(bin_ready_o), 0);
    rst_n = 1'b1;
    tick();

    // STREAM encode of 0..15, one-cycle latency per accepted word
    ready_fix = 1'b1;
    start_run(1'b0);
    for (int i = 0; i < 16; i++) begin
      send(W'(i), 1'b0);
      chk("latency_valid", int'(gray_valid_o), 1);
    end
    stop_pulse();
    wait_idle("stream");

    // Backpressure: FIFO fills at DEPTH, fifth word waits upstream
    ready_fix = 1'b0;
    start_run(1'b0);
    for (int i = 0; i < 4; i++) send(W'(4'hA + i), 1'b0);
    chk("bp_ready_low", int'(bin_ready_o), 0);
    chk("bp_valid", int'(gray_valid_o), 1);
    fork
      begin
        repeat (3) tick();
        ready_fix = 1'b1;
      end
      send(W'(4'h3), 1'b0);
    join
    stop_pulse();
    wait_idle("bp");

    // stop_i on the third accept, then drain
    ready_fix = 1'b0;
    start_run(1'b0);
    send(W'(5), 1'b0);
    send(W'(9), 1'b0);
    send(W'(14), 1'b1);
    chk("drain_busy", int'(busy_o), 1);
    chk("drain_no_ready", int'(bin_ready_o), 0);
    ready_fix = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      #1;
      k++;
    end while (exp_q.size() != 0 && k < 100);
    chk("drain_busy_last", int'(busy_o), 1);
    @(negedge clk);
    chk("drain_busy_fall", int'(busy_o), 0);
    tick();

    // COUNT wrap over 20+ pops
    for (int i = 0; i < 40; i++) exp_q.push_back(W'(gray_tbl[i % 16]));
    base = n_pops;
    ready_fix = 1'b1;
    start_run(1'b1);
    k = 0;
    while ((n_pops - base) < 20 && k < 200) begin
      tick();
      k++;
    end
    chk("count_progress", int'((n_pops - base) >= 20), 1);
    stop_pulse();
    wait_idle("count");
    exp_q.delete();

    // start_i + stop_i together in IDLE with mode COUNT: start wins
    ready_fix = 1'b0;
    mode_i = 1'b1; start_i = 1'b1; stop_i = 1'b1;
    tick();
    start_i = 1'b0; stop_i = 1'b0;
    repeat (6) tick();
    chk("corner_busy", int'(busy_o), 1);
    chk("corner_no_stream", int'(bin_ready_o), 0);
    chk("corner_valid", int'(gray_valid_o), 1);
    for (int i = 0; i < 4; i++) exp_q.push_back(W'(gray_tbl[i]));
    stop_pulse();
    ready_fix = 1'b1;
    wait_idle("corner");
    chk("corner_sb_empty", exp_q.size(), 0);

    // start_i during STREAM is ignored
    start_run(1'b0);
    mode_i = 1'b1; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("start_ignored_ready", int'(bin_ready_o), 1);
    send(W'(7), 1'b0);
    stop_pulse();
    wait_idle("start_ignored");

    // Randomized stream with random downstream backpressure
    ready_rand = 1'b1;
    start_run(1'b0);
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      send(W'($urandom_range(0, 15)), 1'b0);
    end
    stop_pulse();
    ready_rand = 1'b0;
    ready_fix  = 1'b1;
    wait_idle("random");

    // Reset in the middle of COUNT with three words queued
    ready_fix = 1'b0;
    start_run(1'b1);
    repeat (3) tick();
    chk("rst_mid_valid_before", int'(gray_valid_o), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", int'(gray_valid_o), 0);
    chk("rst_mid_busy", int'(busy_o), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_rel_ready", int'(bin_ready_o), 0);
    chk("rst_rel_valid", int'(gray_valid_o), 0);

    chk("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
